// File: rtl/fu_mult_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fu_mult_pipe_pkg
//  Description : Shared types and helpers for the pipelined multiply unit.
//  Revision    : 1.0
// ============================================================================
package fu_mult_pipe_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } mult_func_t;

    localparam int MULT_TAG_W = 6;

    function automatic logic rs1_is_signed(input mult_func_t f);
        return (f == MULH) || (f == MULHSU);
    endfunction

    function automatic logic rs2_is_signed(input mult_func_t f);
        return (f == MULH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fu_mult_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fu_mult_stage
//  Description : One multiply pipeline stage; folds NUM_BITS multiplier bits
//                into the running product when loaded.
//  Revision    : 1.0
// ============================================================================
module fu_mult_stage
    import fu_mult_pipe_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_BITS = 16,
    parameter int TAG_W    = MULT_TAG_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic                load_i,
    input  logic                first_i,
    input  logic                valid_i,
    input  logic [TAG_W-1:0]    tag_i,
    input  logic [1:0]          func_i,
    input  logic [2*XLEN-1:0]   mcand_i,
    input  logic [2*XLEN-1:0]   mplier_i,
    input  logic [2*XLEN-1:0]   product_i,
    output logic                valid_o,
    output logic [TAG_W-1:0]    tag_o,
    output logic [1:0]          func_o,
    output logic [2*XLEN-1:0]   mcand_o,
    output logic [2*XLEN-1:0]   mplier_o,
    output logic [2*XLEN-1:0]   product_o
);

    localparam int PW = 2 * XLEN;

    logic              valid_q;
    logic [TAG_W-1:0]  tag_q;
    logic [1:0]        func_q;
    logic [PW-1:0]     mcand_q;
    logic [PW-1:0]     mplier_q;
    logic [PW-1:0]     product_q;
    logic [PW-1:0]     partial;
    logic [PW-1:0]     product_d;

    assign partial   = PW'(mplier_i[NUM_BITS-1:0]) * mcand_i;
    assign product_d = first_i ? partial : (product_i + partial);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= valid_i;
        end
    end

    // Datapath is qualified by valid_q only, so it carries no reset.
    always_ff @(posedge clock) begin
        if (load_i) begin
            tag_q     <= tag_i;
            func_q    <= func_i;
            mcand_q   <= mcand_i << NUM_BITS;
            mplier_q  <= mplier_i >> NUM_BITS;
            product_q <= product_d;
        end
    end

    assign valid_o   = valid_q;
    assign tag_o     = tag_q;
    assign func_o    = func_q;
    assign mcand_o   = mcand_q;
    assign mplier_o  = mplier_q;
    assign product_o = product_q;

endmodule
`default_nettype wire

// File: rtl/fu_mult_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fu_mult_pipe
//  Description : Pipelined RV32M-style multiplier with valid/ready stall,
//                tag passthrough and flush.
//  Revision    : 1.0
// ============================================================================
module fu_mult_pipe
    import fu_mult_pipe_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NUM_STAGE = 4,
    parameter int TAG_W     = MULT_TAG_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_func,
    input  logic [XLEN-1:0]   in_rs1,
    input  logic [XLEN-1:0]   in_rs2,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int PW       = 2 * XLEN;
    localparam int NUM_BITS = PW / NUM_STAGE;
    localparam int LAST     = NUM_STAGE - 1;

    if ((PW % NUM_STAGE) != 0) begin : g_bad_cfg
        $error("fu_mult_pipe: NUM_STAGE must divide 2*XLEN");
    end

    mult_func_t           func_in;
    logic [PW-1:0]        mcand_ext;
    logic [PW-1:0]        mplier_ext;

    logic [NUM_STAGE-1:0] valid_q;
    logic [NUM_STAGE-1:0] up_valid;
    logic [NUM_STAGE-1:0] adv;
    logic [NUM_STAGE-1:0] load;
    logic [TAG_W-1:0]     tag_q      [NUM_STAGE];
    logic [TAG_W-1:0]     up_tag     [NUM_STAGE];
    logic [1:0]           func_q     [NUM_STAGE];
    logic [1:0]           up_func    [NUM_STAGE];
    logic [PW-1:0]        mcand_q    [NUM_STAGE];
    logic [PW-1:0]        up_mcand   [NUM_STAGE];
    logic [PW-1:0]        mplier_q   [NUM_STAGE];
    logic [PW-1:0]        up_mplier  [NUM_STAGE];
    logic [PW-1:0]        product_q  [NUM_STAGE];
    logic [PW-1:0]        up_product [NUM_STAGE];

    assign func_in    = mult_func_t'(in_func);
    assign mcand_ext  = {{XLEN{rs1_is_signed(func_in) & in_rs1[XLEN-1]}}, in_rs1};
    assign mplier_ext = {{XLEN{rs2_is_signed(func_in) & in_rs2[XLEN-1]}}, in_rs2};

    // Stall propagates backwards from the output: a stage moves when the one
    // ahead of it is empty or moving itself.
    always_comb begin
        adv       = '0;
        adv[LAST] = valid_q[LAST] & out_ready;
        for (int k = NUM_STAGE - 2; k >= 0; k--) begin
            adv[k] = valid_q[k] & (~valid_q[k+1] | adv[k+1]);
        end
    end

    assign load = ~valid_q | adv;

    for (genvar k = 0; k < NUM_STAGE; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign up_valid[k]   = in_valid;
            assign up_tag[k]     = in_tag;
            assign up_func[k]    = in_func;
            assign up_mcand[k]   = mcand_ext;
            assign up_mplier[k]  = mplier_ext;
            assign up_product[k] = '0;
        end else begin : g_tail
            assign up_valid[k]   = valid_q[k-1];
            assign up_tag[k]     = tag_q[k-1];
            assign up_func[k]    = func_q[k-1];
            assign up_mcand[k]   = mcand_q[k-1];
            assign up_mplier[k]  = mplier_q[k-1];
            assign up_product[k] = product_q[k-1];
        end

        fu_mult_stage #(
            .XLEN     (XLEN),
            .NUM_BITS (NUM_BITS),
            .TAG_W    (TAG_W)
        ) u_stage (
            .clock     (clock),
            .reset     (reset),
            .flush     (flush),
            .load_i    (load[k]),
            .first_i   (k == 0),
            .valid_i   (up_valid[k]),
            .tag_i     (up_tag[k]),
            .func_i    (up_func[k]),
            .mcand_i   (up_mcand[k]),
            .mplier_i  (up_mplier[k]),
            .product_i (up_product[k]),
            .valid_o   (valid_q[k]),
            .tag_o     (tag_q[k]),
            .func_o    (func_q[k]),
            .mcand_o   (mcand_q[k]),
            .mplier_o  (mplier_q[k]),
            .product_o (product_q[k])
        );
    end

    assign in_ready   = load[0];
    assign out_valid  = valid_q[LAST] & ~flush;
    assign out_tag    = tag_q[LAST];
    assign out_result = (mult_func_t'(func_q[LAST]) == MUL) ? product_q[LAST][XLEN-1:0]
                                                            : product_q[LAST][PW-1:XLEN];

endmodule
`default_nettype wire
